// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/LSU ports, the arbiter and the
// simple dual-port word memory. The arbiter uses the slave view; the
// environment (requesters plus memory) uses the master view.
interface mem_port_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);
  // Instruction fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [WIDTH-1:0]  if_rdata_o;
  // Load/store port
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [WIDTH-1:0]  d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [WIDTH-1:0]  d_rdata_o;
  // Memory side
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_waddr_o;
  logic [WIDTH-1:0]  mem_wdata_o;
  logic [ADDR_W-1:0] mem_raddr_o;
  logic [WIDTH-1:0]  mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o,
           d_rdata_o, mem_we_o, mem_waddr_o, mem_wdata_o, mem_raddr_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o,
           d_rdata_o, mem_we_o, mem_waddr_o, mem_wdata_o, mem_raddr_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the registered read port of a simple dual-port memory between
// instruction fetch and the load/store unit. D writes go straight to the
// private write port; read conflicts are resolved round-robin. A D write
// that hits the address IF is reading in the same cycle is forwarded so
// IF never sees the stale word the memory returns.
module mem_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input logic              clk_i,
  input logic              rst_ni,
  mem_port_arbiter_if.slave bus
);

  // Which reader won the most recent granted read
  typedef enum logic {
    RD_IF = 1'b0,
    RD_D  = 1'b1
  } rd_port_e;

  rd_port_e          last_rd_r;
  rd_port_e          last_rd_s;

  logic              d_wr_s;
  logic              d_rd_s;
  logic              if_gnt_s;
  logic              d_gnt_s;
  logic              d_rd_gnt_s;
  logic              fwd_s;
  logic [ADDR_W-1:0] raddr_s;

  logic              if_rvalid_r;
  logic              d_rvalid_r;
  logic              fwd_r;
  logic [WIDTH-1:0]  fwd_data_r;
  logic [WIDTH-1:0]  if_hold_r;
  logic [WIDTH-1:0]  d_hold_r;
  logic [WIDTH-1:0]  if_rdata_s;
  logic [WIDTH-1:0]  d_rdata_s;

  // Grant decode; everything on the request side is forced quiet in reset
  always_comb begin
    d_wr_s     = 1'b0;
    d_rd_s     = 1'b0;
    if_gnt_s   = 1'b0;
    d_gnt_s    = 1'b0;
    d_rd_gnt_s = 1'b0;
    fwd_s      = 1'b0;
    raddr_s    = {ADDR_W{1'b0}};
    if (rst_ni) begin
      d_wr_s     = bus.d_req_i & bus.d_we_i;
      d_rd_s     = bus.d_req_i & ~bus.d_we_i;
      // On a read conflict the port that did not win last time goes first
      if_gnt_s   = bus.if_req_i & (~d_rd_s | (last_rd_r == RD_D));
      d_rd_gnt_s = d_rd_s & (~bus.if_req_i | (last_rd_r == RD_IF));
      d_gnt_s    = d_wr_s | d_rd_gnt_s;
      fwd_s      = if_gnt_s & d_wr_s & (bus.d_addr_i == bus.if_addr_i);
      if (if_gnt_s) begin
        raddr_s = bus.if_addr_i;
      end else if (d_rd_gnt_s) begin
        raddr_s = bus.d_addr_i;
      end else begin
        raddr_s = {ADDR_W{1'b0}};
      end
    end else begin
      raddr_s = {ADDR_W{1'b0}};
    end
  end

  // Round-robin next state: remember the winner of any granted read
  always_comb begin
    last_rd_s = last_rd_r;
    if (if_gnt_s) begin
      last_rd_s = RD_IF;
    end else if (d_rd_gnt_s) begin
      last_rd_s = RD_D;
    end else begin
      last_rd_s = last_rd_r;
    end
  end

  // Round-robin state register; after reset D wins the first conflict
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_rd_r <= RD_IF;
    end else begin
      last_rd_r <= last_rd_s;
    end
  end

  // Response pipeline: one-cycle valid pulses plus forwarded write data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      fwd_r       <= 1'b0;
      fwd_data_r  <= {WIDTH{1'b0}};
    end else begin
      if_rvalid_r <= if_gnt_s;
      d_rvalid_r  <= d_rd_gnt_s;
      fwd_r       <= fwd_s;
      fwd_data_r  <= fwd_s ? bus.d_wdata_i : fwd_data_r;
    end
  end

  // Read data hold registers so rdata stays put between responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_hold_r <= {WIDTH{1'b0}};
      d_hold_r  <= {WIDTH{1'b0}};
    end else begin
      if_hold_r <= if_rdata_s;
      d_hold_r  <= d_rdata_s;
    end
  end

  // Read data select: live memory word (or forwarded word) on the response cycle
  always_comb begin
    if_rdata_s = if_hold_r;
    d_rdata_s  = d_hold_r;
    if (if_rvalid_r) begin
      if_rdata_s = fwd_r ? fwd_data_r : bus.mem_rdata_i;
    end else begin
      if_rdata_s = if_hold_r;
    end
    if (d_rvalid_r) begin
      d_rdata_s = bus.mem_rdata_i;
    end else begin
      d_rdata_s = d_hold_r;
    end
  end

  assign bus.if_gnt_o    = if_gnt_s;
  assign bus.d_gnt_o     = d_gnt_s;
  assign bus.if_rvalid_o = if_rvalid_r;
  assign bus.d_rvalid_o  = d_rvalid_r;
  assign bus.if_rdata_o  = if_rdata_s;
  assign bus.d_rdata_o   = d_rdata_s;
  assign bus.mem_we_o    = d_wr_s;
  assign bus.mem_waddr_o = d_wr_s ? bus.d_addr_i : {ADDR_W{1'b0}};
  assign bus.mem_wdata_o = d_wr_s ? bus.d_wdata_i : {WIDTH{1'b0}};
  assign bus.mem_raddr_o = raddr_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a registered-read memory model on the far
// side, a word-level reference model of what each reader must receive,
// directed scenarios plus a randomized request stream.
module tb_mem_port_arbiter;
  localparam int W  = 32;
  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  mem_port_arbiter #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_word(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0001);
  endfunction

  // Memory instance model: write port plus registered read port
  logic [W-1:0] mem_arr [0:NW-1];
  logic         init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < NW; i++) mem_arr[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (bus.mem_we_o) begin
      mem_arr[bus.mem_waddr_o] <= bus.mem_wdata_o;
    end
    bus.mem_rdata_i <= mem_arr[bus.mem_raddr_o];
  end

  // Reference model: word contents seen by the core, pending responses, fairness
  logic [W-1:0] ref_mem [0:NW-1];
  logic         m_if_rv, m_d_rv;
  logic [W-1:0] m_if_data, m_d_data;
  logic         m_last_if;   // last granted read went to IF

  task automatic model_reset();
    m_if_rv   = 1'b0;
    m_d_rv    = 1'b0;
    m_last_if = 1'b1;
  endtask

  task automatic drive(input logic ifr, input logic [AW-1:0] ifa, input logic dr,
                       input logic dw, input logic [AW-1:0] da, input logic [W-1:0] dd);
    bus.if_req_i  = ifr;
    bus.if_addr_i = ifa;
    bus.d_req_i   = dr;
    bus.d_we_i    = dw;
    bus.d_addr_i  = da;
    bus.d_wdata_i = dd;
  endtask

  // One bus cycle: drive, check last cycle's responses, check grants, advance model
  task automatic do_cycle(input logic ifr, input logic [AW-1:0] ifa, input logic dr,
                          input logic dw, input logic [AW-1:0] da, input logic [W-1:0] dd,
                          output logic ig, output logic dg);
    logic          e_ig, e_dg, if_rd, d_rd, d_wr;
    logic [AW-1:0] e_raddr;
    @(negedge clk);
    drive(ifr, ifa, dr, dw, da, dd);
    #1;
    checks++;
    if (bus.if_rvalid_o !== m_if_rv) begin
      failures++; $display("FAIL if_rvalid: got %b want %b", bus.if_rvalid_o, m_if_rv);
    end
    if (m_if_rv) begin
      checks++;
      if (bus.if_rdata_o !== m_if_data) begin
        failures++; $display("FAIL if_rdata: got %h want %h", bus.if_rdata_o, m_if_data);
      end
    end
    checks++;
    if (bus.d_rvalid_o !== m_d_rv) begin
      failures++; $display("FAIL d_rvalid: got %b want %b", bus.d_rvalid_o, m_d_rv);
    end
    if (m_d_rv) begin
      checks++;
      if (bus.d_rdata_o !== m_d_data) begin
        failures++; $display("FAIL d_rdata: got %h want %h", bus.d_rdata_o, m_d_data);
      end
    end
    if_rd = ifr;
    d_rd  = dr & ~dw;
    d_wr  = dr & dw;
    // Lone reader goes first; on conflict the one that did not win last time
    if (if_rd && d_rd) begin
      e_ig = ~m_last_if;
      e_dg = m_last_if;
    end else begin
      e_ig = if_rd;
      e_dg = d_rd | d_wr;
    end
    if (e_ig)               e_raddr = ifa;
    else if (e_dg && d_rd)  e_raddr = da;
    else                    e_raddr = '0;
    checks++;
    if (bus.if_gnt_o !== e_ig || bus.d_gnt_o !== e_dg) begin
      failures++; $display("FAIL grants: got if=%b d=%b want if=%b d=%b",
                           bus.if_gnt_o, bus.d_gnt_o, e_ig, e_dg);
    end
    checks++;
    if (bus.mem_raddr_o !== e_raddr) begin
      failures++; $display("FAIL mem_raddr: got %h want %h", bus.mem_raddr_o, e_raddr);
    end
    checks++;
    if (bus.mem_we_o !== d_wr || bus.mem_waddr_o !== (d_wr ? da : '0) ||
        bus.mem_wdata_o !== (d_wr ? dd : '0)) begin
      failures++; $display("FAIL mem_write: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                           bus.mem_we_o, bus.mem_waddr_o, bus.mem_wdata_o, d_wr, da, dd);
    end
    // A same-cycle write is visible to the reader: apply it before reading
    if (d_wr) ref_mem[da] = dd;
    m_if_rv = e_ig;
    m_d_rv  = e_dg & d_rd;
    if (e_ig) begin
      m_if_data = ref_mem[ifa];
      m_last_if = 1'b1;
    end
    if (e_dg && d_rd) begin
      m_d_data  = ref_mem[da];
      m_last_if = 1'b0;
    end
    ig = e_ig;
    dg = e_dg;
  endtask

  task automatic idle();
    logic ig, dg;
    do_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, ig, dg);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.if_gnt_o !== 1'b0 || bus.d_gnt_o !== 1'b0 || bus.if_rvalid_o !== 1'b0 ||
        bus.d_rvalid_o !== 1'b0 || bus.if_rdata_o !== '0 || bus.d_rdata_o !== '0 ||
        bus.mem_we_o !== 1'b0 || bus.mem_waddr_o !== '0 || bus.mem_wdata_o !== '0 ||
        bus.mem_raddr_o !== '0) begin
      failures++;
      $display("FAIL %s: outputs not all zero in reset (gnt=%b%b rv=%b%b we=%b ra=%h rd=%h/%h)",
               tag, bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o,
               bus.mem_we_o, bus.mem_raddr_o, bus.if_rdata_o, bus.d_rdata_o);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 10'd3, 1'b1, 1'b1, 10'd4, 32'h1111_2222);
    #1;
    check_all_zero("reset_outputs");
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic ig, dg;
    reset_dut();
    idle();
    do_cycle(1'b1, 10'd20, 1'b0, 1'b0, '0, '0, ig, dg);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_read");
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    model_reset();
    idle();
    checks++;
    if (bus.if_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL reset_drop: if_rvalid got %b want 0", bus.if_rvalid_o);
    end
  endtask

  task automatic test_if_read();
    logic ig, dg;
    do_cycle(1'b0, '0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, ig, dg);
    do_cycle(1'b1, 10'd5, 1'b0, 1'b0, '0, '0, ig, dg);
    checks++;
    if (bus.if_gnt_o !== 1'b1) begin
      failures++; $display("FAIL if_read_gnt: got %b want 1", bus.if_gnt_o);
    end
    idle();
    checks++;
    if (bus.if_rvalid_o !== 1'b1 || bus.if_rdata_o !== 32'hDEAD_BEEF || bus.d_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL if_read_data: got rv=%b data=%h drv=%b want 1 deadbeef 0",
                           bus.if_rvalid_o, bus.if_rdata_o, bus.d_rvalid_o);
    end
  endtask

  task automatic test_alternate();
    logic ig, dg;
    reset_dut();
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, '0, ig, dg);
      checks++;
      if (bus.d_gnt_o !== ((k % 2) == 0) || bus.if_gnt_o !== ((k % 2) == 1)) begin
        failures++; $display("FAIL alternate[%0d]: got if=%b d=%b want d first then alternate",
                             k, bus.if_gnt_o, bus.d_gnt_o);
      end
    end
    idle();
  endtask

  task automatic test_forward();
    logic ig, dg;
    do_cycle(1'b0, '0, 1'b1, 1'b1, 10'd7, 32'h0, ig, dg);
    do_cycle(1'b1, 10'd7, 1'b1, 1'b1, 10'd7, 32'h1234_5678, ig, dg);
    checks++;
    if (bus.if_gnt_o !== 1'b1 || bus.d_gnt_o !== 1'b1) begin
      failures++; $display("FAIL fwd_gnt: got if=%b d=%b want 1 1", bus.if_gnt_o, bus.d_gnt_o);
    end
    do_cycle(1'b1, 10'd7, 1'b0, 1'b0, '0, '0, ig, dg);
    checks++;
    if (bus.if_rdata_o !== 32'h1234_5678) begin
      failures++; $display("FAIL fwd_data: got %h want 12345678", bus.if_rdata_o);
    end
    idle();
    checks++;
    if (bus.if_rdata_o !== 32'h1234_5678) begin
      failures++; $display("FAIL fwd_reread: got %h want 12345678", bus.if_rdata_o);
    end
  endtask

  task automatic test_write_other();
    logic ig, dg;
    do_cycle(1'b1, 10'd4, 1'b1, 1'b1, 10'd3, 32'hCAFE_0003, ig, dg);
    checks++;
    if (bus.mem_we_o !== 1'b1 || bus.mem_waddr_o !== 10'd3 || bus.if_gnt_o !== 1'b1) begin
      failures++; $display("FAIL write_other: got we=%b wa=%h ig=%b want 1 003 1",
                           bus.mem_we_o, bus.mem_waddr_o, bus.if_gnt_o);
    end
    idle();
    checks++;
    if (bus.if_rdata_o !== init_word(4) || bus.d_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL write_other_rd: got %h drv=%b want %h 0",
                           bus.if_rdata_o, bus.d_rvalid_o, init_word(4));
    end
  endtask

  task automatic test_wrap();
    logic          ig, dg;
    logic [AW:0]   wide;
    wide = 11'd1033;
    do_cycle(1'b0, '0, 1'b1, 1'b0, wide[AW-1:0], '0, ig, dg);
    checks++;
    if (bus.mem_raddr_o !== 10'd9) begin
      failures++; $display("FAIL wrap_addr: got %h want 009", bus.mem_raddr_o);
    end
    idle();
    checks++;
    if (bus.d_rdata_o !== init_word(9)) begin
      failures++; $display("FAIL wrap_data: got %h want %h", bus.d_rdata_o, init_word(9));
    end
  endtask

  task automatic test_random();
    logic          ig, dg;
    logic          if_p, d_p, d_w;
    logic [AW-1:0] if_a, d_a;
    logic [W-1:0]  d_d;
    if_p = 1'b0; d_p = 1'b0; d_w = 1'b0;
    if_a = '0; d_a = '0; d_d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!if_p && $urandom_range(0, 3) != 0) begin
        if_p = 1'b1;
        if_a = AW'($urandom_range(0, 15));
      end
      if (!d_p && $urandom_range(0, 3) != 0) begin
        d_p = 1'b1;
        d_w = 1'($urandom_range(0, 1));
        d_a = AW'($urandom_range(0, 15));
        d_d = $urandom;
      end
      do_cycle(if_p, if_a, d_p, d_w, d_a, d_d, ig, dg);
      if (ig) if_p = 1'b0;
      if (dg) d_p = 1'b0;
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_if_read();
    test_alternate();
    test_forward();
    test_write_other();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single registered read port of the simple dual-port word memory between two requesters:
  - instruction fetch (IF), read-only;
  - load/store unit (D), read or write.
- Drives the memory's independent write port from D writes.
- Round-robin arbitration on read conflicts.
- Returns each read with a tagged one-cycle response and forwards same-cycle write data so readers never see stale words.
- Sits between the core's fetch/LSU and the memory instance.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_W, 10, word address width; memory holds 2**ADDR_W words.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- if_req_i  in  1  IF read request.
- if_addr_i  in  ADDR_W  IF word address.
- if_gnt_o  out  1  IF request accepted this cycle.
- if_rvalid_o  out  1  IF read data valid.
- if_rdata_o  out  WIDTH  IF read data.
- d_req_i  in  1  D request.
- d_we_i  in  1  D request is a write (1) or read (0).
- d_addr_i  in  ADDR_W  D word address.
- d_wdata_i  in  WIDTH  D write data.
- d_gnt_o  out  1  D request accepted this cycle.
- d_rvalid_o  out  1  D read data valid; never asserted for writes.
- d_rdata_o  out  WIDTH  D read data.
- mem_we_o  out  1  memory write enable.
- mem_waddr_o  out  ADDR_W  memory write address.
- mem_wdata_o  out  WIDTH  memory write data.
- mem_raddr_o  out  ADDR_W  memory read address.
- mem_rdata_i  in  WIDTH  memory read data, registered, valid the cycle after mem_raddr_o.

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Handshake:
  - Requester holds req/addr/we/wdata stable until gnt.
  - Transfer occurs on a cycle with req&&gnt.
  - gnt is combinational from the current req inputs.
- D write: always granted in its cycle (write port is private).
  - mem_we_o=1, mem_waddr_o=d_addr_i, mem_wdata_o=d_wdata_i in that cycle.
  - Otherwise mem_we_o=0; waddr/wdata=0.
- Read arbitration:
  - Only one of IF read / D read is granted per cycle.
  - Single reader is granted immediately.
  - Both IF and D-read requesting: winner is the port NOT recorded in last_rd.
  - last_rd updates to the winner on every granted read.
  - D write + IF read in the same cycle: both granted.
- mem_raddr_o = granted reader's address; 0 when no read granted.
- Latency: read granted in cycle N, response in cycle N+1.
  - Only the owner's rvalid is pulsed for 1 cycle.
  - rdata is held until the next response; not meaningful while rvalid=0.
- Forwarding:
  - Applies when an IF read is granted in the same cycle as a D write to the same address.
  - The memory returns old data in that case.
  - The block registers d_wdata_i and returns it as if_rdata_o at N+1 instead of mem_rdata_i.
- Back-to-back: a new read may be granted every cycle. No response buffering is needed; the single response register pipeline is sufficient.
- Reset, all outputs:
  - gnt=0, rvalid=0, rdata=0.
  - mem_we_o=0; mem_waddr_o, mem_wdata_o, mem_raddr_o = 0.
- Reset, internal state: last_rd=IF, so D wins the first conflict; forward flag=0.
- Reset mid-operation: an in-flight response is dropped with no rvalid after release. Memory contents are not touched.
- Address wrap: addresses are used modulo 2**ADDR_W; no bounds check.
- Idle (no req): no gnt, no rvalid next cycle, last_rd unchanged.

Test Plan:
- Reset asserted mid-read (IF granted at N, rst_ni low before N+1) -> no if_rvalid_o after release; all outputs 0 during reset.
- IF-only read of addr 5 containing 0xDEADBEEF -> if_gnt_o=1 same cycle, if_rvalid_o=1 and if_rdata_o=0xDEADBEEF next cycle, d_rvalid_o=0.
- IF and D both read every cycle for 6 cycles (addrs 1 and 2) after reset -> grants alternate D,IF,D,IF,D,IF; each response lands one cycle later on the matching port only.
- D write 0x12345678 to addr 7 while IF reads addr 7 (old 0) -> both granted; if_rdata_o=0x12345678 next cycle; subsequent IF read of 7 also returns 0x12345678.
- D write to addr 3 while IF reads addr 4 -> both granted, mem_we_o=1, IF gets old contents of 4; d_rvalid_o never asserts.
- D read addr 2**ADDR_W+9 -> mem_raddr_o=9; data of word 9 returned on d_rdata_o.
